// File: rtl/iomem_stream_fifo_pkg.sv
// Register map and bit positions shared by the iomem stream FIFO top and its bench.
package iomem_stream_fifo_pkg;

   localparam logic [7:0] REG_DATA   = 8'h00;
   localparam logic [7:0] REG_STATUS = 8'h04;
   localparam logic [7:0] REG_CTRL   = 8'h08;

   localparam int unsigned DATA_VALID = 31;

   localparam int unsigned STAT_OVF   = 31;
   localparam int unsigned STAT_FULL  = 17;
   localparam int unsigned STAT_EMPTY = 16;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_IRQEN   = 1;
   localparam int unsigned CTRL_FLUSH   = 2;
   localparam int unsigned CTRL_THR_LSB = 16;

endpackage

// File: rtl/stream_fifo_core.sv
// Byte FIFO core: wrapping pointers, level counter, dual-port storage, push/pop/flush.
module stream_fifo_core #(
   parameter int unsigned DEPTH = 512,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned LW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [7:0]    wdata_i,
   output logic [7:0]    rdata_o,
   output logic [LW-1:0] level_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push_ok, pop_ok;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok) && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/iomem_stream_fifo.sv
// iomem slave exposing a camera byte-stream FIFO as DATA/STATUS/CTRL registers.
// Define IOMEM_STREAM_FIFO_IRQ_EN to build the threshold/overflow interrupt.
module iomem_stream_fifo
   import iomem_stream_fifo_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
   parameter int unsigned DEPTH     = 512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        irq
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic          ready_q;
   logic [31:0]   rdata_q, rdata_d;
   logic          ovf_q, ovf_d;
   logic          ctrl_en_q;
   logic          ctrl_irqen;
   logic [15:0]   thr;
   logic          hit, req, rd_req, wr_req;
   logic [7:0]    offset;
   logic          pop, push, flush, ovf_set, ovf_clr, ctrl_wr;
   logic [7:0]    head;
   logic [LW-1:0] level;
   logic [15:0]   level16;
   logic          full, empty;
   logic          unused_bits;

   assign hit    = (iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign offset = iomem_addr[7:0];
   // ready_q blocks a second decode of the request still held during its ack cycle.
   assign req    = iomem_valid && hit && !ready_q;
   assign rd_req = req && (iomem_wstrb == 4'b0000);
   assign wr_req = req && (iomem_wstrb != 4'b0000);

   assign pop     = rd_req && (offset == REG_DATA) && !empty;
   assign ctrl_wr = wr_req && (offset == REG_CTRL);
   assign flush   = ctrl_wr && iomem_wstrb[0] && iomem_wdata[CTRL_FLUSH];
   assign ovf_clr = wr_req && (offset == REG_STATUS) && iomem_wstrb[3] && iomem_wdata[STAT_OVF];
   assign push    = s_valid && ctrl_en_q && !flush;
   assign ovf_set = push && full && !pop;
   assign ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   assign level16 = 16'(level);

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign unused_bits = ^{iomem_wdata, iomem_wstrb};

   stream_fifo_core #(
      .DEPTH (DEPTH)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (s_data),
      .rdata_o (head),
      .level_o (level),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      rdata_d = '0;
      case (offset)
         REG_DATA: begin
            if (!empty) begin
               rdata_d[DATA_VALID] = 1'b1;
               rdata_d[7:0]        = head;
            end
         end
         REG_STATUS: begin
            rdata_d[STAT_OVF]   = ovf_q;
            rdata_d[STAT_FULL]  = full;
            rdata_d[STAT_EMPTY] = empty;
            rdata_d[15:0]       = level16;
         end
         REG_CTRL: begin
            rdata_d[CTRL_EN]           = ctrl_en_q;
            rdata_d[CTRL_IRQEN]        = ctrl_irqen;
            rdata_d[31:CTRL_THR_LSB]   = thr;
         end
         default: rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q   <= 1'b0;
         rdata_q   <= '0;
         ovf_q     <= 1'b0;
         ctrl_en_q <= 1'b0;
      end else begin
         ready_q <= req;
         rdata_q <= rd_req ? rdata_d : '0;
         ovf_q   <= ovf_d;
         if (ctrl_wr && iomem_wstrb[0]) ctrl_en_q <= iomem_wdata[CTRL_EN];
      end
   end

`ifdef IOMEM_STREAM_FIFO_IRQ_EN
   logic        ctrl_irqen_q;
   logic [15:0] thr_q;
   logic        irq_q;

   assign ctrl_irqen = ctrl_irqen_q;
   assign thr        = thr_q;
   assign irq        = irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_irqen_q <= 1'b0;
         thr_q        <= '0;
         irq_q        <= 1'b0;
      end else begin
         if (ctrl_wr && iomem_wstrb[0]) ctrl_irqen_q <= iomem_wdata[CTRL_IRQEN];
         if (ctrl_wr && iomem_wstrb[2]) thr_q[7:0]   <= iomem_wdata[CTRL_THR_LSB +: 8];
         if (ctrl_wr && iomem_wstrb[3]) thr_q[15:8]  <= iomem_wdata[CTRL_THR_LSB + 8 +: 8];
         irq_q <= ctrl_irqen_q && ((level16 >= thr_q) || ovf_q);
      end
   end
`else
   assign ctrl_irqen = 1'b0;
   assign thr        = '0;
   assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_stream_fifo.sv
// Scoreboard bench for iomem_stream_fifo: a byte queue models the FIFO contents.
module tb_iomem_stream_fifo;
   import iomem_stream_fifo_pkg::*;

   localparam int unsigned DEPTH = 512;
   localparam logic [31:0] BASE  = 32'h0300_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] sb[$];
   bit         en_m  = 1'b0;
   bit         ovf_m = 1'b0;

   iomem_stream_fifo #(
      .BASE_ADDR (BASE),
      .DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] status_exp();
      return {ovf_m, 13'b0, sb.size() == DEPTH, sb.size() == 0, 16'(sb.size())};
   endfunction

   task automatic model_push(input logic [7:0] b);
      if (en_m) begin
         if (sb.size() < DEPTH) sb.push_back(b);
         else ovf_m = 1'b1;
      end
   endtask

   // One bus transaction; sv/sd put a stream byte on the request cycle only.
   task automatic bus(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd,
                      input bit sv, input logic [7:0] sd,
                      output logic [31:0] rd, output int lat);
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = BASE | 32'(off);
      iomem_wstrb = strb;
      iomem_wdata = wd;
      s_valid     = sv;
      s_data      = sd;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         s_valid = 1'b0;
      end while (!iomem_ready && lat < 8);
      check("bus_ready", {31'b0, iomem_ready}, 32'd1);
      rd = iomem_rdata;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0;
   endtask

   task automatic reg_read(input string tag, input logic [7:0] off, input logic [31:0] exp);
      logic [31:0] rd;
      int lat;
      bus(off, 4'b0, 32'b0, 1'b0, 8'h0, rd, lat);
      check(tag, rd, exp);
   endtask

   task automatic reg_write(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd);
      logic [31:0] rd;
      int lat;
      bus(off, strb, wd, 1'b0, 8'h0, rd, lat);
   endtask

   task automatic ctrl_write(input logic [31:0] wd, input bit sv, input logic [7:0] sd);
      logic [31:0] rd;
      int lat;
      bus(REG_CTRL, 4'hf, wd, sv, sd, rd, lat);
      if (sv && !wd[2]) model_push(sd);
      en_m = wd[0];
      if (wd[2]) sb.delete();
   endtask

   task automatic read_data(input string tag, input bit sv, input logic [7:0] sd);
      logic [31:0] rd, exp;
      logic [7:0]  b;
      int lat;
      exp = 32'h0;
      if (sb.size() > 0) begin
         b   = sb.pop_front();
         exp = {1'b1, 23'b0, b};
      end
      if (sv) model_push(sd);
      bus(REG_DATA, 4'b0, 32'b0, sv, sd, rd, lat);
      check(tag, rd, exp);
   endtask

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      @(negedge clk);
      s_valid = 1'b0;
      model_push(b);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int lat;
      int cnt;

      reset = 1'b1;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0;
      iomem_addr  = 32'b0;
      iomem_wdata = 32'b0;
      s_valid     = 1'b0;
      s_data      = 8'h0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'b0, iomem_ready}, 32'd0);
      check("rst_rdata", iomem_rdata, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      reset = 1'b0;

      // Request issued while reset is high never gets acknowledged.
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = BASE | 32'(REG_STATUS);
      reset       = 1'b1;
      @(negedge clk);
      check("rst_abort_ready", {31'b0, iomem_ready}, 32'd0);
      iomem_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_abort_ready2", {31'b0, iomem_ready}, 32'd0);

      // 1: STATUS after reset, single-cycle ready
      bus(REG_STATUS, 4'b0, 32'b0, 1'b0, 8'h0, rd, lat);
      check("t1_status", rd, 32'h0001_0000);
      check("t1_latency", lat, 32'd1);
      @(negedge clk);
      check("t1_ready_drop", {31'b0, iomem_ready}, 32'd0);
      reg_read("t1_ctrl", REG_CTRL, 32'h0);

      // Non-hit address: no response.
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0400_0004;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (iomem_ready) cnt++;
      end
      iomem_valid = 1'b0;
      check("nohit_ready", cnt, 32'd0);

      // Disabled stream is ignored without overflow.
      push(8'h11);
      reg_read("dis_status", REG_STATUS, status_exp());

      // 2: basic push/pop
      ctrl_write(32'h1, 1'b0, 8'h0);
      push(8'hA5);
      push(8'h3C);
      for (int i = 0; i < 3; i++) read_data("t2_data", 1'b0, 8'h0);
      reg_read("t2_status", REG_STATUS, status_exp());

      // Empty + push + read in one cycle: read sees empty, byte kept.
      read_data("t2_empty_push_read", 1'b1, 8'h77);
      reg_read("t2_level1", REG_STATUS, status_exp());
      read_data("t2_kept", 1'b0, 8'h0);

      // 3: overflow
      for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom));
      reg_read("t3_full_ovf", REG_STATUS, status_exp());
      reg_write(REG_STATUS, 4'b0111, 32'h8000_0000);
      reg_read("t3_ovf_kept", REG_STATUS, status_exp());
      reg_write(REG_STATUS, 4'b1000, 32'h8000_0000);
      ovf_m = 1'b0;
      reg_read("t3_ovf_clr", REG_STATUS, status_exp());
      for (int i = 0; i < DEPTH; i++) read_data("t3_data", 1'b0, 8'h0);
      reg_read("t3_empty", REG_STATUS, status_exp());

      // 4: full with simultaneous push and pop, wrapping
      for (int i = 0; i < DEPTH; i++) push(8'($urandom));
      reg_read("t4_full", REG_STATUS, status_exp());
      for (int i = 0; i < 2 * DEPTH; i++) read_data("t4_pushpop", 1'b1, 8'($urandom));
      reg_read("t4_still_full", REG_STATUS, status_exp());
      for (int i = 0; i < DEPTH; i++) read_data("t4_drain", 1'b0, 8'h0);

      // 5: flush
      for (int i = 0; i < 10; i++) push(8'(i + 1));
      ctrl_write(32'h5, 1'b0, 8'h0);
      reg_read("t5_status", REG_STATUS, status_exp());
      reg_read("t5_ctrl", REG_CTRL, 32'h1);
      for (int i = 0; i < 3; i++) push(8'(i + 8'h20));
      ctrl_write(32'h5, 1'b1, 8'h99);
      reg_read("t5_flush_push", REG_STATUS, status_exp());
      push(8'h42);
      read_data("t5_after_flush", 1'b0, 8'h0);

      // 6: interrupt
`ifdef IOMEM_STREAM_FIFO_IRQ_EN
      ctrl_write(32'h0004_0003, 1'b0, 8'h0);
      reg_read("t6_ctrl", REG_CTRL, 32'h0004_0003);
      for (int i = 0; i < 3; i++) push(8'(i));
      repeat (2) @(negedge clk);
      check("t6_irq_below", {31'b0, irq}, 32'd0);
      push(8'h03);
      repeat (2) @(negedge clk);
      check("t6_irq_at_thr", {31'b0, irq}, 32'd1);
      read_data("t6_data", 1'b0, 8'h0);
      repeat (2) @(negedge clk);
      check("t6_irq_drop", {31'b0, irq}, 32'd0);
      for (int i = 0; i < 3; i++) read_data("t6_drain", 1'b0, 8'h0);
      ctrl_write(32'h0000_0003, 1'b0, 8'h0);
      repeat (2) @(negedge clk);
      check("t6_irq_thr0", {31'b0, irq}, 32'd1);
`else
      ctrl_write(32'h0004_0003, 1'b0, 8'h0);
      reg_read("t6_ctrl", REG_CTRL, 32'h1);
      for (int i = 0; i < 4; i++) push(8'(i));
      repeat (2) @(negedge clk);
      check("t6_irq_off", {31'b0, irq}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
